// File: rtl/ram_ws_ctrl_if.sv
// Memory bus between the TinyMIPS core and ram_ws_ctrl: request, data and status lines.
interface ram_ws_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] adr;
  logic [WIDTH-1:0]  writedata;
  logic [WIDTH-1:0]  memdata;
  logic              ready;
  logic              done;
  logic [15:0]       store_cnt;

  modport master (
    output memread, memwrite, adr, writedata,
    input  memdata, ready, done, store_cnt
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output memdata, ready, done, store_cnt
  );
endinterface

// File: rtl/ram_ws_ctrl.sv
// TinyMIPS program/data memory with programmable wait states, a one-cycle ready pulse,
// a sticky end-of-test flag and a saturating store counter.
module ram_ws_ctrl #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       WAIT      = 0,
  parameter bit                HALT_ANY  = 1'b1,
  parameter logic [ADDR_W-1:0] HALT_ADR  = '1,
  parameter                    INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  ram_ws_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  logic [WIDTH-1:0]  r_mem [2**ADDR_W];

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_we;
  logic [WIDTH-1:0]  r_memdata;
  logic              r_done;
  logic [15:0]       r_store_cnt;

  logic              w_req;
  logic              w_commit;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_adr;
  logic [WIDTH-1:0]  w_acc_wdata;
  logic              w_do_write;
  logic              w_do_read;

  assign w_req = bus.memread | bus.memwrite;

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT == 0) begin
            w_next   = S_ACK;
            w_commit = 1'b1;
          end else begin
            w_next   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_ACK;
          w_commit = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With WAIT=0 the access commits on the accept edge, before anything is latched,
  // so the live bus values are used in IDLE and the latched copies otherwise.
  assign w_acc_we    = (r_state == S_IDLE) ? bus.memwrite  : r_we;
  assign w_acc_adr   = (r_state == S_IDLE) ? bus.adr       : r_adr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.writedata : r_wdata;
  assign w_do_write  = w_commit &  w_acc_we;
  assign w_do_read   = w_commit & ~w_acc_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_memdata   <= '0;
      r_done      <= 1'b0;
      r_store_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_cnt   <= WAIT_LD;
        r_adr   <= bus.adr;
        r_wdata <= bus.writedata;
        r_we    <= bus.memwrite;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_read) begin
        r_memdata <= r_mem[w_acc_adr];
      end
      if (w_do_write) begin
        if (r_store_cnt != '1) begin
          r_store_cnt <= r_store_cnt + 16'd1;
        end
        if (HALT_ANY || (w_acc_adr == HALT_ADR)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  // Array is not reset; gating with rst keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (w_do_write && rst) begin
      r_mem[w_acc_adr] <= w_acc_wdata;
    end
  end

  assign bus.memdata   = r_memdata;
  assign bus.ready     = (r_state == S_ACK);
  assign bus.done      = r_done;
  assign bus.store_cnt = r_store_cnt;

endmodule
